rcas_seq_alu: RTL
=================

// Module: rcas_seq_alu
// PURPOSE
//  Parametrised, multi-cycle add/subtract unit with a valid/ready handshake on both sides.
//  Processes CHUNK bits per clock through a chunk ripple adder, LSB chunk first.
//  Adds add-with-carry and subtract-with-borrow.
//  Flags use the calculator convention {cout, ovr, neg, zero}.
//  Sits between the calculator operand registers and the result/display path.
// PARAMETERS
//  W      8  operand/result width in bits; must be >= 1
//  CHUNK  4  bits processed per cycle; must satisfy W % CHUNK == 0; N = W/CHUNK
// PORTS
//  clk        in   1      single clock; all state changes on its rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a, b, op and cin are valid
//  in_ready   out  1      unit can accept an operation
//  a          in   W      operand A
//  b          in   W      operand B
//  op         in   2      00 add, 01 sub, 10 add+cin, 11 sub+cin (cin=1 means no borrow)
//  cin        in   1      carry/borrow input; used only when op[1]=1
//  out_valid  out  1      s and flags are valid
//  out_ready  in   1      downstream accepts the result
//  s          out  W      result
//  flags      out  4      {cout, ovr, neg, zero}
// BEHAVIOUR
//  - States: IDLE -> BUSY -> DONE -> IDLE.
//  - in_ready = (state==IDLE) & ~rst.
//  - out_valid = (state==DONE).
//  - Reset:
//    - At the reset edge: state=IDLE, chunk index=0, s=0, flags=0, out_valid=0.
//    - Reset mid-BUSY or mid-DONE aborts the operation and discards the result.
//  - Accept (IDLE & in_valid):
//    - Latch a, op, and b_eff = op[0] ? ~b : b.
//    - Carry register := op[1] ? cin : op[0].
//    - idx := 0; go to BUSY.
//    - Inputs are ignored outside IDLE.
//  - BUSY, each cycle:
//    - Add chunk idx of a and b_eff with the carry register.
//    - Write the chunk sum into s[idx*CHUNK +: CHUNK].
//    - Carry register := chunk carry-out.
//    - idx++.
//  - BUSY, on the last chunk (idx == N-1):
//    - cout = chunk carry-out.
//    - ovr = carry-out XOR carry into bit W-1 (taken inside the chunk).
//    - neg = s[W-1]; zero = (full W-bit s == 0).
//    - Go to DONE.
//  - Latency: out_valid is high N cycles after the accepting edge.
//    - CHUNK == W gives 1 cycle.
//  - DONE: s and flags are held stable until out_valid & out_ready; then go to IDLE.
//    - This leaves one bubble before the next accept; back-to-back throughput is one op per N+2 cycles.
//  - s is not valid while BUSY (partial chunks are visible); consumers must qualify it with out_valid.
//  - Arithmetic: modulo 2^W.
//    - Subtract cout=1 means no borrow.
//    - ovr is signed two's-complement overflow.
//  - Index counter width: $clog2(N) bits, minimum 1; it never wraps past N-1.
// STRUCTURE
//  - Shared package rcas_pkg: op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC), state encodings,
//    flag bit positions (FLG_C=3, FLG_V=2, FLG_N=1, FLG_Z=0).
//  - Sub-module rcas_chunk #(CHUNK): combinational ripple adder.
//    - Inputs: a, b, ci.
//    - Outputs: sum, co, c_msb (carry into the top bit of the chunk).
//  - Top level: FSM, operand/carry registers, chunk mux/demux, flag logic.
// TESTING
//  Default W=8, CHUNK=4 unless stated.
//  1. Add 0x7F + 0x01 (op 00) -> s=0x80, flags=4'b0110; out_valid exactly 2 cycles after the accept.
//  2. Sub 0x05 - 0x05 (op 01) -> s=0x00, flags=4'b1001.
//  3. Sub 0x00 - 0x01 (op 01) -> s=0xFF, flags=4'b0010.
//  4. Add+cin 0xFF + 0x00, cin=1 (op 10) -> s=0x00, flags=4'b1001.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands.
//     -> s/flags stable, in_ready=0, new operands not taken.
//     -> After out_ready=1 the next op is accepted exactly 1 cycle later.
//  6. Reset mid-BUSY (rst=1 for 1 cycle after chunk 0).
//     -> out_valid never rises for that op; s=0, flags=0.
//     -> in_ready=1 the cycle rst drops.
//  7. W=16, CHUNK=1: 0x8000 - 0x0001 (op 01) -> s=0x7FFF, flags=4'b1100, latency 16 cycles.

Source files
------------

// File: rtl/rcas_pkg.sv
// Shared encodings for the chunked ripple add/subtract unit.
package rcas_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    // Subtract is a + ~b + 1, so without an explicit carry the seed equals op[0].
    function automatic logic carry_seed(input logic [1:0] op, input logic cin);
        return op[1] ? cin : op[0];
    endfunction

endpackage

// File: rtl/rcas_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
module rcas_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    // Bit-serial ripple through the chunk.
    always_comb begin
        logic [CHUNK:0] v_c;
        v_c    = {(CHUNK+1){1'b0}};
        sum    = {CHUNK{1'b0}};
        v_c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ v_c[i];
            v_c[i+1] = (a[i] & b[i]) | (v_c[i] & (a[i] ^ b[i]));
        end
        co    = v_c[CHUNK];
        c_msb = v_c[CHUNK-1];
    end

endmodule

// File: rtl/rcas_seq_alu.sv
// Multi-cycle add/subtract unit: one CHUNK-bit slice per clock, LSB slice first,
// with valid/ready on both sides and {cout, ovr, neg, zero} flags.
module rcas_seq_alu #(
    parameter int W     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic [3:0]   flags
);
    import rcas_pkg::*;

    localparam int N  = W / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e         r_state;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_s;
    logic           r_carry;
    logic [3:0]     r_flags;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_co;
    logic             w_c_msb;
    logic [W-1:0]     w_s_next;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

    rcas_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (w_a_chunk),
        .b     (w_b_chunk),
        .ci    (r_carry),
        .sum   (w_sum),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    // Result with the current chunk merged in, so flags see the full final word.
    always_comb begin
        w_s_next = r_s;
        w_s_next[r_idx*CHUNK +: CHUNK] = w_sum;
    end

    // Control FSM plus operand, carry, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= {IW{1'b0}};
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_s     <= {W{1'b0}};
            r_carry <= 1'b0;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= op[0] ? ~b : b;
                        r_carry <= carry_seed(op, cin);
                        r_idx   <= {IW{1'b0}};
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_s     <= w_s_next;
                    r_carry <= w_co;
                    if (r_idx == LAST_IDX) begin
                        r_flags[FLG_C] <= w_co;
                        r_flags[FLG_V] <= w_co ^ w_c_msb;
                        r_flags[FLG_N] <= w_s_next[W-1];
                        r_flags[FLG_Z] <= (w_s_next == {W{1'b0}});
                        r_state        <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign out_valid = (r_state == ST_DONE);
    assign s         = r_s;
    assign flags     = r_flags;

endmodule
